// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time counter: digit widths,
// the seconds limit, the operating-mode encoding and small helpers.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEC_MAX = 59;

  typedef logic [DIGIT_W-1:0]   bcd_digit_t;
  typedef logic [2*DIGIT_W-1:0] bcd_pair_t;

  // Mode is re-derived every cycle; ADJUST outranks RUN, RUN outranks PAUSE.
  typedef enum logic [1:0] {
    MODE_PAUSE  = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_ADJUST = 2'd2
  } mode_e;

  // A level that is high now but was low last cycle is a rising edge.
  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  // Converts a small integer (0..99) into a packed two-digit BCD pair.
  function automatic bcd_pair_t to_bcd2(input int unsigned value);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = DIGIT_W'(value / 10);
    ones = DIGIT_W'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that rolls over to 00 after reaching a programmable
// BCD maximum. The carry output tells the caller that this increment wrapped.
module bcd2_counter
  import stopwatch_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst,
  input  logic       inc,
  input  bcd_pair_t  max,
  output bcd_digit_t tens,
  output bcd_digit_t ones,
  output logic       carry
);

  bcd_digit_t tens_q, tens_d;
  bcd_digit_t ones_q, ones_d;
  logic       at_max;

  // Next-value logic: wrap at (or, defensively, beyond) max, else BCD increment.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    at_max = ({tens_q, ones_q} >= max);
    carry  = inc & at_max;
    if (inc) begin
      if (at_max) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers with synchronous reset to 00.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/stopwatch_time_counter.sv
// MM:SS stopwatch core. Edge-detects the divided tick/adjust square waves in
// the clk_in domain, then steers them into a seconds and a minutes BCD
// counter depending on the current mode (adjust, run or pause).
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN      = 59,
  parameter bit          RUN_AT_RESET = 1'b1
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               tick_src,
  input  logic               adj_src,
  input  logic               pause_toggle,
  input  logic               adj,
  input  logic               sel,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               wrap
);

  localparam bcd_pair_t MIN_MAX_BCD = to_bcd2(MAX_MIN);
  localparam bcd_pair_t SEC_MAX_BCD = to_bcd2(SEC_MAX);

  logic  tick_q, tick_d;
  logic  adj_q, adj_d;
  logic  running_q, running_d;
  logic  wrap_q, wrap_d;

  logic  tick_en;
  logic  adj_en;
  mode_e mode;
  logic  sec_inc, min_inc;
  logic  sec_carry, min_carry;

  assign tick_en = rise_edge(tick_src, tick_q);
  assign adj_en  = rise_edge(adj_src, adj_q);

  // Mode selection, counter steering, wrap detection and run/pause toggling.
  // A pause_toggle arriving with a tick sees the pre-toggle mode, so the
  // tick still counts and the pause takes effect from the next cycle.
  always_comb begin
    tick_d    = tick_src;
    adj_d     = adj_src;
    running_d = running_q;
    wrap_d    = 1'b0;
    sec_inc   = 1'b0;
    min_inc   = 1'b0;
    mode      = MODE_PAUSE;

    if (adj) begin
      mode = MODE_ADJUST;
    end else if (running_q) begin
      mode = MODE_RUN;
    end

    case (mode)
      MODE_ADJUST: begin
        sec_inc = adj_en & sel;
        min_inc = adj_en & ~sel;
      end
      MODE_RUN: begin
        sec_inc = tick_en;
        min_inc = sec_carry;
        wrap_d  = min_carry;
      end
      default: begin
        sec_inc = 1'b0;
        min_inc = 1'b0;
      end
    endcase

    if (pause_toggle) begin
      running_d = ~running_q;
    end
  end

  // Edge history, run flag and registered wrap pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tick_q    <= 1'b0;
      adj_q     <= 1'b0;
      running_q <= RUN_AT_RESET;
      wrap_q    <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      adj_q     <= adj_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  bcd2_counter u_seconds (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (sec_inc),
    .max    (SEC_MAX_BCD),
    .tens   (sec_tens),
    .ones   (sec_ones),
    .carry  (sec_carry)
  );

  bcd2_counter u_minutes (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (min_inc),
    .max    (MIN_MAX_BCD),
    .tens   (min_tens),
    .ones   (min_ones),
    .carry  (min_carry)
  );

  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
- Downstream consumer of the divide-by-32 clock stage. Takes the divided square wave(s) as level inputs in the clk_in domain and edge-detects them into single-cycle enables.
- Keeps MM:SS time as four BCD digits and supports run/pause plus a manual adjust mode.
- Output digits feed the display mux stage. Fully synchronous to clk_in; no logic clocked by a divided clock.

Parameters:
- MAX_MIN, 59, highest minute value before wrap (2-digit BCD, valid range 1..99)
- RUN_AT_RESET, 1, value of `running` after reset (1 = counting, 0 = paused)

Ports:
- clk_in  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tick_src  input  1  divided clock for counting (from the divider); rising edge = +1 s
- adj_src  input  1  divided clock for adjust rate; rising edge = one adjust step
- pause_toggle  input  1  one-cycle pulse (already debounced); flips run/pause
- adj  input  1  level; 1 = adjust mode
- sel  input  1  adjust target; 0 = minutes, 1 = seconds
- min_tens  output  4  BCD
- min_ones  output  4  BCD
- sec_tens  output  4  BCD, 0..5
- sec_ones  output  4  BCD
- running  output  1  1 = RUN state
- wrap  output  1  one-cycle pulse when the time wraps MAX_MIN:59 -> 00:00 in count mode

Behaviour:
- Reset (rst=1 at a clk_in edge):
  - All digits 0, `wrap`=0, `running`=RUN_AT_RESET.
  - tick_q=0 and adj_q=0 (edge-detect history registers).
  - Reset dominates every other input. Mid-operation reset clears the time on that edge.
- Edge detect:
  - tick_en = tick_src & ~tick_q; adj_en = adj_src & ~adj_q (combinational).
  - tick_q <= tick_src and adj_q <= adj_src every cycle.
  - Digits update on the same clk_in edge that first samples tick_src=1, i.e. zero added latency beyond one register stage.
  - With the 32x divider, tick_en fires once every 32 clk_in cycles.
- Modes, derived each cycle (priority ADJUST > RUN > PAUSE):
  - ADJUST (adj=1):
    - tick_en is ignored and dropped, not queued.
    - On adj_en, the selected field increments by 1: seconds mod 60, minutes mod (MAX_MIN+1). No carry between fields.
    - `running` is unchanged and `wrap` is never asserted.
  - RUN (adj=0, running=1):
    - On tick_en, seconds increment. At xx:59 seconds go to 00 and minutes +1.
    - At MAX_MIN:59 the time goes to 00:00 and `wrap`=1 for exactly that cycle.
  - PAUSE (adj=0, running=0): digits hold.
- pause_toggle:
  - Flips `running` on the edge it is sampled, in any mode, including ADJUST.
  - Same cycle as tick_en: the tick is evaluated with the pre-toggle state. Example: running=1 and both pulses arrive → count once, then pause.
- Leaving adjust: counting resumes on the next tick_en. No catch-up.
- BCD rules:
  - ones digit 9 → 0 with carry into tens.
  - sec_tens 5 with sec_ones 9 → 00 with carry into minutes.
  - Digits never hold non-BCD values.
- `wrap` is registered and is 0 in every cycle except the wrap cycle.

Decomposition:
- Shared package (stopwatch_pkg):
  - BCD digit width constant (4)
  - SEC_MAX constant (59)
  - mode encoding constants MODE_PAUSE / MODE_RUN / MODE_ADJUST
  - rising-edge-detect helper function
- Sub-module bcd2_counter:
  - Two-digit BCD counter; ports clk_in, rst, inc, max (BCD pair), tens, ones, carry.
  - carry is combinational and high when inc is asserted at max.
  - Instantiated twice: seconds with max=59, minutes with max=MAX_MIN.
  - The top gates inc/carry per mode.

Test Plan:
- rst 2 cycles, then the 32x divider drives tick_src, adj=0 → after 60 tick edges (1920 clk_in cycles), digits = 0,1,0,0 (01:00); `running`=1 throughout.
- Adjust to 59:59 (adj=1; sel=0 for 59 adj_en, then sel=1 for 59), then adj=0 with one tick edge → 00:00 and `wrap`=1 for exactly 1 cycle, then 0.
- At 00:10, pulse pause_toggle → 40 tick edges leave 00:10 and running=0; pulse again → after 5 ticks, 00:15.
- At 00:58, adj=1, sel=1, 3 adj_en pulses → 00:01; minutes stay 00; tick edges during adjust change nothing.
- At 00:05 running, tick_en and pause_toggle in the same cycle → 00:06 and running=0; the next tick leaves 00:06.
- Counting at 12:34, assert rst for 1 cycle coincident with tick_en → next cycle 00:00, running=RUN_AT_RESET, wrap=0.
